// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared definitions for the MEM stage of the LoongArch pipeline.
//   - Bus widths between exe/mem and mem/wb.
//   - Packed layouts of both buses.
//   - Helper that picks the value the stage hands on.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int EXE_TO_MEM_BUS_WD = 73;
    localparam int MEM_TO_WB_BUS_WD  = 70;

    // {inst_ld_w[72], inst_lu12i_w[71], load_op[70], gr_we[69], dest[68:64],
    //  alu_result[63:32], pc[31:0]}
    typedef struct packed {
        logic        inst_ld_w;
        logic        inst_lu12i_w;
        logic        load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } exe_to_mem_t;

    // {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } mem_to_wb_t;

    // Loads return memory data; everything else (lu12i.w included) has its
    // value already computed in alu_result.
    function automatic logic [31:0] sel_result(input logic        load_op,
                                               input logic [31:0] mem_rdata,
                                               input logic [31:0] alu_result);
        return load_op ? mem_rdata : alu_result;
    endfunction

endpackage

// File: rtl/mem_if.sv
// -----------------------------------------------------------------------------
// mem_if: handshake and data signals around the MEM stage.
//   exe_to_mem_valid / exe_to_mem_bus : instruction arriving from exe
//   mem_allowin                       : MEM can accept this cycle
//   data_sram_rdata                   : SRAM read data (one cycle after request)
//   wb_allowin                        : write-back can accept
//   mem_to_wb_valid / mem_to_wb_bus   : instruction leaving towards write-back
//   gr_we_mem / dest_mem / forward_data_mem : hazard/forward info for decode
// Modports: slave = the MEM stage, master = its surroundings.
// -----------------------------------------------------------------------------
interface mem_if;
    import mem_pkg::*;

    logic        exe_to_mem_valid;
    exe_to_mem_t exe_to_mem_bus;
    logic        mem_allowin;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    mem_to_wb_t  mem_to_wb_bus;
    logic        gr_we_mem;
    logic [4:0]  dest_mem;
    logic [31:0] forward_data_mem;

    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem
    );

    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem
    );

endinterface

// File: rtl/mem_rdata_hold.sv
// -----------------------------------------------------------------------------
// mem_rdata_hold: keeps the load data alive while write-back stalls.
// SRAM data is only valid in the cycle right after the request, so it is
// latched on that first cycle and replayed for the rest of the stall.
// Config macro: MEM_RDATA_HOLD_EN (undefined -> straight pass-through, only
// correct when write-back never stalls a load).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   capture         : MEM pipeline register loads a new instruction this cycle
//   mem_valid       : MEM stage holds an instruction
//   data_sram_rdata : live SRAM read data
//   mem_rdata       : load data to use for the current instruction
// -----------------------------------------------------------------------------
module mem_rdata_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        mem_valid,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] mem_rdata
);

`ifdef MEM_RDATA_HOLD_EN
    logic        first_cyc;
    logic [31:0] rdata_q;

    // first_cyc marks the one cycle in which SRAM data belongs to the
    // instruction just captured; a capture on the same edge the old one
    // leaves re-arms it for the newcomer.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_cyc <= 1'b0;
            rdata_q   <= '0;
        end else begin
            first_cyc <= capture;
            if (first_cyc && mem_valid) begin
                rdata_q <= data_sram_rdata;
            end
        end
    end

    assign mem_rdata = first_cyc ? data_sram_rdata : rdata_q;
`else
    logic unused_ctrl;

    assign unused_ctrl = ^{clk, reset, capture, mem_valid};
    assign mem_rdata   = data_sram_rdata;
`endif

endmodule

// File: rtl/mem.sv
// -----------------------------------------------------------------------------
// mem: memory-access stage of the five-stage LoongArch pipeline.
// Accepts exe's instruction under valid/allowin, merges the SRAM load data
// (held across write-back stalls by mem_rdata_hold), selects the result and
// forwards it to write-back and, valid-qualified, back to decode.
// Config macro: MEM_RDATA_HOLD_EN (enables the read-data hold register).
// Ports:
//   clk   : sole clock
//   reset : synchronous, active-high
//   bus   : mem_if.slave carrying all handshake, data and forward signals
// -----------------------------------------------------------------------------
module mem
    import mem_pkg::*;
(
    input logic  clk,
    input logic  reset,
    mem_if.slave bus
);

    exe_to_mem_t mem_rec;
    logic        mem_valid;
    logic        mem_ready_go;
    logic        capture;
    logic [31:0] mem_rdata;
    logic [31:0] final_result;
    logic        unused_fields;

    // MEM never waits on anything of its own.
    assign mem_ready_go    = 1'b1;
    assign bus.mem_allowin = !mem_valid || (mem_ready_go && bus.wb_allowin);
    assign capture         = bus.exe_to_mem_valid && bus.mem_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (bus.mem_allowin) begin
            mem_valid <= bus.exe_to_mem_valid;
        end
    end

    // Payload is qualified by mem_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_rec <= bus.exe_to_mem_bus;
        end
    end

    mem_rdata_hold u_rdata_hold (
        .clk             (clk),
        .reset           (reset),
        .capture         (capture),
        .mem_valid       (mem_valid),
        .data_sram_rdata (bus.data_sram_rdata),
        .mem_rdata       (mem_rdata)
    );

    assign final_result = sel_result(mem_rec.load_op, mem_rdata, mem_rec.alu_result);

    assign bus.mem_to_wb_valid = mem_valid && mem_ready_go;
    assign bus.mem_to_wb_bus   = '{gr_we:        mem_rec.gr_we,
                                   dest:         mem_rec.dest,
                                   final_result: final_result,
                                   pc:           mem_rec.pc};

    assign bus.gr_we_mem        = mem_valid && mem_rec.gr_we;
    assign bus.dest_mem         = mem_valid ? mem_rec.dest : 5'd0;
    assign bus.forward_data_mem = mem_valid ? final_result : 32'd0;

    // Load data is resolved here and lu12i.w is folded into alu_result
    // upstream, so neither opcode flag is needed in this stage.
    assign unused_fields = mem_rec.inst_ld_w ^ mem_rec.inst_lu12i_w;

endmodule
